mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RV32I pipeline. It consumes the EX/MEM pipeline register outputs and performs byte-serial loads and stores through the shared byte-wide memory arbiter. It raises a stall request while an access is in flight and presents the write-back triple to the MEM/WB register. Non-memory instructions pass straight through with no added latency.

## Interface
- INST_IDX_W, 6: width of the instruction-index field; encodings come from the shared defines.
- clk_in  in  1  clock, all state on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; low freezes all state and forces memReq_out low.
- instIdx_in  in  INST_IDX_W  decoded instruction id (idLB/LH/LW/LBU/LHU/SB/SH/SW, others non-memory).
- memAddr_in  in  18  byte address of the access.
- valStore_in  in  32  store data.
- rdE_in, rdIdx_in, rdData_in  in  1/5/32  write-back triple from EX.
- hold_in  in  1  downstream stall; keeps the stage in DONE.
- memGnt_in  in  1  arbiter accepted this cycle's byte request.
- memRvalid_in  in  1  read byte valid, exactly one cycle after a granted read.
- memRdata_in  in  8  read byte.
- memReq_out  out  1  byte request.
- memWr_out  out  1  request is a write.
- memAddr_out  out  18  byte address.
- memWdata_out  out  8  write byte.
- stallReq_out  out  1  stall IF..EX_MEM.
- rdE_out, rdIdx_out, rdData_out  out  1/5/32  to MEM/WB.

## Operation
- FSM states:
  - IDLE:
    - Memory op on input → BUSY.
    - Otherwise pass rd* through combinationally; stallReq_out=0.
  - BUSY:
    - Request byte k (k = issue counter, 0..N-1; N=1/2/4 for B/H/W); memAddr_out = memAddr_in + k, mod 2^18.
    - memWdata_out = valStore_in[8k+7:8k].
    - Counter advances only on memGnt_in; memReq_out deasserts once N bytes are granted.
    - Reads: the j-th memRvalid_in byte goes to lane j of a 32-bit assembly register (little-endian).
    - Stores: → DONE on the edge where the last byte is granted.
    - Loads: → DONE on the edge where the last byte returns.
  - DONE:
    - stallReq_out=0.
    - Loads: rdData_out = assembly value sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
    - Stores: rdE_out=0.
    - hold_in=1 stays DONE; else → IDLE.
- stallReq_out = 1 in IDLE-with-memory-op and in BUSY.
- rdE_out/rdIdx_out pass through for loads in DONE.
- Misaligned addresses are legal and are simply byte-serial.
- memRvalid_in outside BUSY-load is ignored.
- rdy_in low: no state change, no counter change, memReq_out=0; a grant seen while rdy_in is low is ignored.

## Timing
- Reset (rst_in low, async): state IDLE, counters/assembly cleared.
- While rst_in is low, all outputs are 0:
  - memReq_out, memWr_out, memAddr_out, memWdata_out
  - stallReq_out
  - rdE_out, rdIdx_out, rdData_out
- Reset mid-access abandons the access. Late read data is ignored.
- Non-memory op: zero-cycle combinational pass-through.
- With continuous grant, op presented in cycle 0:
  - Requests in cycles 1..N.
  - Store DONE in cycle N+1.
  - Load data returns in cycles 2..N+1; load DONE in cycle N+2.
  - stallReq_out is high from cycle 0 through the cycle before DONE.
- Grant gaps extend BUSY by one cycle per ungranted request cycle.
- Simultaneous last grant and hold_in: DONE is still entered; hold_in only affects leaving DONE.

## Structure
- Shared defines hold:
  - instruction-id encodings (idLB..idSW, idNOP)
  - zero constants
  - FSM state encodings
  - address width 18
- One sub-module, mem_load_ext: combinational size/sign extension of the assembly register. All else is in mem_stage.

## Test plan
- Reset: drive LW and then assert rst_in mid-BUSY → all outputs 0 immediately; after release, state is IDLE and memReq_out stays 0.
- ADD pass-through: rdE=1, rd=5, data=0x1234 → same values at output in cycle 0, stallReq_out=0, no memReq_out.
- LW @0x00100, continuous grant:
  - memory bytes 0x78,0x56,0x34,0x12 at 0x00100..0x00103.
  - Expect requests at addresses 0x00100..0x00103 in cycles 1–4.
  - Expect DONE in cycle 6 with rdData_out=0x12345678 and stall high in cycles 0–5.
- LB/LBU @0x3FFFF, byte 0x80:
  - LB → 0xFFFFFF80; LBU → 0x00000080.
  - LH @0x3FFFF reads addresses 0x3FFFF then 0x00000 (wrap).
- SH @0x00010, data 0xAABBCCDD, grant withheld in cycle 2:
  - Writes 0xDD@0x00010 then 0xCC@0x00011.
  - DONE in cycle 4 with rdE_out=0.
- LW finishing with hold_in=1 for 3 cycles:
  - Stage stays DONE, rdData_out is stable, no new requests.
  - Leaves to IDLE on the cycle after hold_in drops.
  - Toggling rdy_in low during BUSY freezes the byte counter.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: instruction ids, state encodings,
// access sizes and the decoder that maps an instruction id onto an access descriptor.
package mem_stage_pkg;

  localparam int ID_W   = 6;
  localparam int ADDR_W = 18;

  localparam logic [ID_W-1:0] ID_NOP = 6'd0;
  localparam logic [ID_W-1:0] ID_LB  = 6'd1;
  localparam logic [ID_W-1:0] ID_LH  = 6'd2;
  localparam logic [ID_W-1:0] ID_LW  = 6'd3;
  localparam logic [ID_W-1:0] ID_LBU = 6'd4;
  localparam logic [ID_W-1:0] ID_LHU = 6'd5;
  localparam logic [ID_W-1:0] ID_SB  = 6'd6;
  localparam logic [ID_W-1:0] ID_SH  = 6'd7;
  localparam logic [ID_W-1:0] ID_SW  = 6'd8;

  localparam logic [31:0]       ZERO_WORD = 32'd0;
  localparam logic [7:0]        ZERO_BYTE = 8'd0;
  localparam logic [4:0]        ZERO_IDX  = 5'd0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic  is_mem;
    logic  is_load;
    logic  sext;
    size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [ID_W-1:0] id);
    mem_op_t op;
    op = '{is_mem: 1'b0, is_load: 1'b0, sext: 1'b0, size: SZ_W};
    case (id)
      ID_LB:   op = '{is_mem: 1'b1, is_load: 1'b1, sext: 1'b1, size: SZ_B};
      ID_LH:   op = '{is_mem: 1'b1, is_load: 1'b1, sext: 1'b1, size: SZ_H};
      ID_LW:   op = '{is_mem: 1'b1, is_load: 1'b1, sext: 1'b0, size: SZ_W};
      ID_LBU:  op = '{is_mem: 1'b1, is_load: 1'b1, sext: 1'b0, size: SZ_B};
      ID_LHU:  op = '{is_mem: 1'b1, is_load: 1'b1, sext: 1'b0, size: SZ_H};
      ID_SB:   op = '{is_mem: 1'b1, is_load: 1'b0, sext: 1'b0, size: SZ_B};
      ID_SH:   op = '{is_mem: 1'b1, is_load: 1'b0, sext: 1'b0, size: SZ_H};
      ID_SW:   op = '{is_mem: 1'b1, is_load: 1'b0, sext: 1'b0, size: SZ_W};
      default: op = '{is_mem: 1'b0, is_load: 1'b0, sext: 1'b0, size: SZ_W};
    endcase
    return op;
  endfunction

  function automatic logic [2:0] op_bytes(input size_e size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Size and sign extension of the little-endian load assembly register.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw,
  input  size_e       size,
  input  logic        sext,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_B:    ext = {{24{sext & raw[7]}}, raw[7:0]};
      SZ_H:    ext = {{16{sext & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores through the shared byte-wide arbiter,
// stall request while an access is in flight, zero-latency pass-through otherwise.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int INST_IDX_W = ID_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [INST_IDX_W-1:0] instIdx_in,
  input  logic [ADDR_W-1:0]     memAddr_in,
  input  logic [31:0]           valStore_in,
  input  logic                  rdE_in,
  input  logic [4:0]            rdIdx_in,
  input  logic [31:0]           rdData_in,
  input  logic                  hold_in,
  input  logic                  memGnt_in,
  input  logic                  memRvalid_in,
  input  logic [7:0]            memRdata_in,
  output logic                  memReq_out,
  output logic                  memWr_out,
  output logic [ADDR_W-1:0]     memAddr_out,
  output logic [7:0]            memWdata_out,
  output logic                  stallReq_out,
  output logic                  rdE_out,
  output logic [4:0]            rdIdx_out,
  output logic [31:0]           rdData_out
);

  state_e            state, state_nx;
  logic [2:0]        iss_cnt, ret_cnt;
  logic [31:0]       asm_data;
  mem_op_t           op;
  logic [2:0]        n_bytes;
  logic              req, gnt_ok, rvalid_ok, last_gnt, last_ret;
  logic [31:0]       load_val;

  logic              mem_req, mem_wr, stall, rd_e;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [4:0]        rd_idx;
  logic [31:0]       rd_data;

  assign op      = decode_op(ID_W'(instIdx_in));
  assign n_bytes = op_bytes(op.size);

  // A request is live until every byte has been granted; rdy_in low masks it and any grant.
  assign req       = rdy_in && (state == ST_BUSY) && (iss_cnt < n_bytes);
  assign gnt_ok    = req && memGnt_in;
  assign last_gnt  = gnt_ok && (iss_cnt == n_bytes - 3'd1);
  assign rvalid_ok = rdy_in && (state == ST_BUSY) && op.is_load && memRvalid_in
                     && (ret_cnt < n_bytes);
  assign last_ret  = rvalid_ok && (ret_cnt == n_bytes - 3'd1);

  mem_load_ext u_load_ext (
    .raw  (asm_data),
    .size (op.size),
    .sext (op.sext),
    .ext  (load_val)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      iss_cnt  <= 3'd0;
      ret_cnt  <= 3'd0;
      asm_data <= ZERO_WORD;
    end else begin
      state <= state_nx;
      if (rdy_in && (state == ST_IDLE)) begin
        iss_cnt  <= 3'd0;
        ret_cnt  <= 3'd0;
        asm_data <= ZERO_WORD;
      end
      if (gnt_ok) iss_cnt <= iss_cnt + 3'd1;
      if (rvalid_ok) begin
        asm_data[{ret_cnt[1:0], 3'b000} +: 8] <= memRdata_in;
        ret_cnt <= ret_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = ZERO_ADDR;
    mem_wdata = ZERO_BYTE;
    stall     = 1'b0;
    rd_e      = rdE_in;
    rd_idx    = rdIdx_in;
    rd_data   = rdData_in;
    case (state)
      ST_IDLE: begin
        if (op.is_mem) begin
          stall = 1'b1;
          rd_e  = 1'b0;
          if (rdy_in) state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall     = 1'b1;
        rd_e      = 1'b0;
        mem_req   = req;
        mem_wr    = req && !op.is_load;
        mem_addr  = memAddr_in + ADDR_W'(iss_cnt);
        mem_wdata = valStore_in[{iss_cnt[1:0], 3'b000} +: 8];
        // Stores finish on the last grant, loads on the last returned byte.
        if (op.is_load ? last_ret : last_gnt) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (op.is_load) rd_data = load_val;
        else            rd_e    = 1'b0;
        if (rdy_in && !hold_in) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Every output reads as zero for as long as reset is asserted.
  assign memReq_out   = rst_in & mem_req;
  assign memWr_out    = rst_in & mem_wr;
  assign memAddr_out  = rst_in ? mem_addr  : ZERO_ADDR;
  assign memWdata_out = rst_in ? mem_wdata : ZERO_BYTE;
  assign stallReq_out = rst_in & stall;
  assign rdE_out      = rst_in & rd_e;
  assign rdIdx_out    = rst_in ? rd_idx  : ZERO_IDX;
  assign rdData_out   = rst_in ? rd_data : ZERO_WORD;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-wide memory responder plus a reference model
// that computes load results and store effects arithmetically from a byte array.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [5:0] ID_ADD = 6'd33;
  localparam int MEM_SZ = 1 << 18;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [5:0]  instIdx_in = ID_NOP;
  logic [17:0] memAddr_in = '0;
  logic [31:0] valStore_in = '0;
  logic        rdE_in = 1'b0;
  logic [4:0]  rdIdx_in = '0;
  logic [31:0] rdData_in = '0;
  logic        hold_in = 1'b0;
  logic        memGnt_in = 1'b0;
  logic        memRvalid_in = 1'b0;
  logic [7:0]  memRdata_in = '0;
  logic        memReq_out, memWr_out, stallReq_out, rdE_out;
  logic [17:0] memAddr_out;
  logic [7:0]  memWdata_out;
  logic [4:0]  rdIdx_out;
  logic [31:0] rdData_out;

  int n_cmp = 0;
  int n_mis = 0;

  mem_stage #(.INST_IDX_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .instIdx_in(instIdx_in),
    .memAddr_in(memAddr_in), .valStore_in(valStore_in), .rdE_in(rdE_in),
    .rdIdx_in(rdIdx_in), .rdData_in(rdData_in), .hold_in(hold_in),
    .memGnt_in(memGnt_in), .memRvalid_in(memRvalid_in), .memRdata_in(memRdata_in),
    .memReq_out(memReq_out), .memWr_out(memWr_out), .memAddr_out(memAddr_out),
    .memWdata_out(memWdata_out), .stallReq_out(stallReq_out), .rdE_out(rdE_out),
    .rdIdx_out(rdIdx_out), .rdData_out(rdData_out)
  );

  always #5 clk_in = ~clk_in;

  // Memory: bytes written by the DUT, bytes preloaded by the bench, else a hash of the address.
  bit         wr_vld   [0:MEM_SZ-1];
  logic [7:0] wr_dat   [0:MEM_SZ-1];
  bit         init_vld [0:MEM_SZ-1];
  logic [7:0] init_dat [0:MEM_SZ-1];

  function automatic logic [7:0] mem_rd(input logic [17:0] a);
    if (wr_vld[a]) return wr_dat[a];
    if (init_vld[a]) return init_dat[a];
    return 8'(({14'd0, a} * 32'd37) ^ 32'h5A);
  endfunction

  always @(posedge clk_in) begin
    memRvalid_in <= 1'b0;
    if (memReq_out && memGnt_in) begin
      if (memWr_out) begin
        wr_vld[memAddr_out] <= 1'b1;
        wr_dat[memAddr_out] <= memWdata_out;
      end else begin
        memRvalid_in <= 1'b1;
        memRdata_in  <= mem_rd(memAddr_out);
      end
    end
  end

  function automatic int nbytes(input logic [5:0] id);
    case (id)
      ID_LB, ID_LBU, ID_SB: return 1;
      ID_LH, ID_LHU, ID_SH: return 2;
      ID_LW, ID_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit is_load(input logic [5:0] id);
    return (id == ID_LB) || (id == ID_LH) || (id == ID_LW) || (id == ID_LBU) || (id == ID_LHU);
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] id, input logic [17:0] a);
    longint v = 0;
    int n = nbytes(id);
    for (int k = 0; k < n; k++) v += longint'(mem_rd(a + 18'(k))) << (8 * k);
    if (((id == ID_LB) || (id == ID_LH)) && (v >= (longint'(1) << (8 * n - 1))))
      v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  typedef struct { int cyc; logic [17:0] a; logic wr; logic [7:0] d; logic g; } req_t;
  req_t        req_q[$];
  int          done_cyc;
  int          rdy_low_req;
  logic        stall0;
  logic [31:0] done_data;
  logic        done_rde;

  // Presents one memory op from cycle 0 and runs until the stall drops (DONE), bounded.
  task automatic drive_op(input logic [5:0] id, input logic [17:0] a, input logic [31:0] sd,
                          input int gnt_pct, input logic [31:0] gnt_off,
                          input logic [31:0] rdy_off);
    bit found = 0;
    req_q.delete();
    done_cyc = -1;
    rdy_low_req = 0;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) begin @(posedge clk_in); #1; end
      instIdx_in  = id;
      memAddr_in  = a;
      valStore_in = sd;
      rdy_in      = (c < 32) ? !rdy_off[c] : 1'b1;
      memGnt_in   = ((c < 32) ? !gnt_off[c] : 1'b1) && (int'($urandom_range(0, 99)) < gnt_pct);
      #1;
      if (c == 0) stall0 = stallReq_out;
      if (!rdy_in && memReq_out) rdy_low_req++;
      if (memReq_out)
        req_q.push_back('{cyc: c, a: memAddr_out, wr: memWr_out, d: memWdata_out, g: memGnt_in});
      if (c > 0 && !stallReq_out) begin
        done_cyc  = c;
        done_data = rdData_out;
        done_rde  = rdE_out;
        found = 1;
      end
      if (found) break;
    end
  endtask

  task automatic finish_op();
    @(posedge clk_in); #1;
    instIdx_in = ID_NOP;
    hold_in    = 1'b0;
    rdy_in     = 1'b1;
    memGnt_in  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [66:0] obs;
    rst_in = 1'b0; rdy_in = 1'b1; instIdx_in = ID_ADD; rdE_in = 1'b1; rdIdx_in = 5'd7;
    rdData_in = 32'hDEADBEEF; memAddr_in = 18'h155; valStore_in = 32'hFFFFFFFF;
    #1;
    obs = {memReq_out, memWr_out, memAddr_out, memWdata_out, stallReq_out, rdE_out, rdIdx_out, rdData_out};
    n_cmp++;
    if (obs !== 67'd0) begin n_mis++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    instIdx_in = ID_LW; memAddr_in = 18'h00200; memGnt_in = 1'b1;
    #1;
    n_cmp++;
    if (stallReq_out !== 1'b1) begin n_mis++; $display("FAIL reset_lw_stall0: got %b expected 1", stallReq_out); end
    @(posedge clk_in); #1;
    n_cmp++;
    if (memReq_out !== 1'b1) begin n_mis++; $display("FAIL reset_lw_req1: got %b expected 1", memReq_out); end
    @(posedge clk_in); #3;
    rst_in = 1'b0;
    #1;
    obs = {memReq_out, memWr_out, memAddr_out, memWdata_out, stallReq_out, rdE_out, rdIdx_out, rdData_out};
    n_cmp++;
    if (obs !== 67'd0) begin n_mis++; $display("FAIL reset_midbusy: got %h expected 0", obs); end
    instIdx_in = ID_NOP; memGnt_in = 1'b0;
    @(posedge clk_in); @(posedge clk_in); #3;
    rst_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      memGnt_in = 1'b1;
      #1;
      n_cmp++;
      if ({memReq_out, stallReq_out, rdE_out, rdData_out} !== {1'b0, 1'b0, 1'b1, 32'hDEADBEEF}) begin
        n_mis++;
        $display("FAIL reset_idle_after: got req=%b stall=%b rdE=%b data=%h expected 0 0 1 deadbeef",
                 memReq_out, stallReq_out, rdE_out, rdData_out);
      end
    end
    memGnt_in = 1'b0;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      instIdx_in = (i == 2) ? ID_NOP : ID_ADD;
      rdE_in    = (i == 0) ? 1'b1 : 1'($urandom);
      rdIdx_in  = (i == 0) ? 5'd5 : 5'($urandom);
      rdData_in = (i == 0) ? 32'h1234 : $urandom;
      #1;
      n_cmp++;
      if ({rdE_out, rdIdx_out, rdData_out} !== {rdE_in, rdIdx_in, rdData_in}) begin
        n_mis++;
        $display("FAIL pass_rd: got %b/%0d/%h expected %b/%0d/%h",
                 rdE_out, rdIdx_out, rdData_out, rdE_in, rdIdx_in, rdData_in);
      end
      n_cmp++;
      if ({stallReq_out, memReq_out} !== 2'b00) begin
        n_mis++; $display("FAIL pass_stall_req: got %b%b expected 00", stallReq_out, memReq_out);
      end
    end
  endtask

  task automatic test_load_word();
    logic [7:0] bytes_t [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int k = 0; k < 4; k++) begin
      init_vld[18'h100 + 18'(k)] = 1'b1;
      init_dat[18'h100 + 18'(k)] = bytes_t[k];
    end
    rdE_in = 1'b1; rdIdx_in = 5'd9; rdData_in = 32'hCAFE0000;
    drive_op(ID_LW, 18'h00100, 32'h0, 100, 32'h0, 32'h0);
    n_cmp++;
    if (stall0 !== 1'b1) begin n_mis++; $display("FAIL lw_stall_c0: got %b expected 1", stall0); end
    n_cmp++;
    if (done_cyc != 6) begin n_mis++; $display("FAIL lw_done_cycle: got %0d expected 6", done_cyc); end
    n_cmp++;
    if ({done_rde, done_data} !== {1'b1, 32'h12345678}) begin
      n_mis++; $display("FAIL lw_data: got %b/%h expected 1/12345678", done_rde, done_data);
    end
    n_cmp++;
    if (req_q.size() != 4) begin n_mis++; $display("FAIL lw_req_count: got %0d expected 4", req_q.size()); end
    for (int k = 0; k < req_q.size() && k < 4; k++) begin
      n_cmp++;
      if (req_q[k].cyc != k + 1 || req_q[k].a !== 18'h100 + 18'(k) || req_q[k].wr !== 1'b0) begin
        n_mis++;
        $display("FAIL lw_req%0d: got cyc=%0d addr=%h wr=%b expected cyc=%0d addr=%h wr=0",
                 k, req_q[k].cyc, req_q[k].a, req_q[k].wr, k + 1, 18'h100 + 18'(k));
      end
    end
    finish_op();
    n_cmp++;
    if ({stallReq_out, memReq_out} !== 2'b00) begin
      n_mis++; $display("FAIL lw_idle_after: got %b%b expected 00", stallReq_out, memReq_out);
    end
  endtask

  task automatic test_load_edge();
    logic [5:0]  ids  [4] = '{ID_LB, ID_LBU, ID_LH, ID_LHU};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9180, 32'h00009180};
    init_vld[18'h3FFFF] = 1'b1; init_dat[18'h3FFFF] = 8'h80;
    init_vld[18'h00000] = 1'b1; init_dat[18'h00000] = 8'h91;
    rdE_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op(ids[i], 18'h3FFFF, 32'h0, 100, 32'h0, 32'h0);
      n_cmp++;
      if (done_cyc != nbytes(ids[i]) + 2 || done_data !== exps[i]) begin
        n_mis++;
        $display("FAIL edge_load%0d: got cyc=%0d data=%h expected cyc=%0d data=%h",
                 i, done_cyc, done_data, nbytes(ids[i]) + 2, exps[i]);
      end
      if (nbytes(ids[i]) == 2) begin
        n_cmp++;
        if (req_q.size() != 2 || req_q[0].a !== 18'h3FFFF || req_q[1].a !== 18'h00000) begin
          n_mis++;
          $display("FAIL edge_wrap: got %0d reqs first=%h expected 2 reqs 3ffff then 00000",
                   req_q.size(), (req_q.size() > 0) ? req_q[0].a : 18'h0);
        end
      end
      finish_op();
    end
  endtask

  task automatic test_store_gap();
    logic [7:0] snap;
    int ng = 0;
    snap = mem_rd(18'h00012);
    rdE_in = 1'b1;
    drive_op(ID_SH, 18'h00010, 32'hAABBCCDD, 100, 32'h4, 32'h0);
    n_cmp++;
    if (done_cyc != 4 || done_rde !== 1'b0) begin
      n_mis++; $display("FAIL sh_done: got cyc=%0d rdE=%b expected cyc=4 rdE=0", done_cyc, done_rde);
    end
    n_cmp++;
    if ({mem_rd(18'h10), mem_rd(18'h11), mem_rd(18'h12)} !== {8'hDD, 8'hCC, snap}) begin
      n_mis++;
      $display("FAIL sh_mem: got %h %h %h expected dd cc %h", mem_rd(18'h10), mem_rd(18'h11),
               mem_rd(18'h12), snap);
    end
    for (int i = 0; i < req_q.size(); i++) if (req_q[i].g && req_q[i].wr) ng++;
    n_cmp++;
    if (ng != 2) begin n_mis++; $display("FAIL sh_grants: got %0d expected 2", ng); end
    finish_op();
  endtask

  task automatic test_hold_rdy();
    logic [17:0] a, ea;
    logic [31:0] exp_v, sd;
    int j = 0;
    a = 18'($urandom);
    exp_v = ref_load(ID_LW, a);
    rdE_in = 1'b1;
    hold_in = 1'b1;
    drive_op(ID_LW, a, 32'h0, 100, 32'h0, 32'h0);
    n_cmp++;
    if (done_cyc != 6 || done_data !== exp_v) begin
      n_mis++; $display("FAIL hold_lw: got cyc=%0d data=%h expected cyc=6 data=%h", done_cyc, done_data, exp_v);
    end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk_in); #1;
      memGnt_in = 1'b1;
      if (i == 3) hold_in = 1'b0;
      #1;
      n_cmp++;
      if ({stallReq_out, memReq_out, rdData_out} !== {2'b00, exp_v}) begin
        n_mis++;
        $display("FAIL hold_stay%0d: got stall=%b req=%b data=%h expected 0 0 %h",
                 i, stallReq_out, memReq_out, rdData_out, exp_v);
      end
    end
    @(posedge clk_in); #1;
    instIdx_in = ID_NOP; memGnt_in = 1'b0; rdData_in = 32'h0BAD0BAD;
    #1;
    n_cmp++;
    if ({stallReq_out, rdE_out, rdData_out} !== {1'b0, 1'b1, 32'h0BAD0BAD}) begin
      n_mis++;
      $display("FAIL hold_leave: got stall=%b rdE=%b data=%h expected 0 1 0bad0bad",
               stallReq_out, rdE_out, rdData_out);
    end
    a = 18'($urandom);
    sd = $urandom;
    drive_op(ID_SW, a, sd, 100, 32'h0, 32'hC);
    n_cmp++;
    if (done_cyc != 7 || rdy_low_req != 0) begin
      n_mis++; $display("FAIL rdy_sw: got cyc=%0d lowreq=%0d expected cyc=7 lowreq=0", done_cyc, rdy_low_req);
    end
    for (int i = 0; i < req_q.size(); i++) begin
      if (req_q[i].g) begin
        ea = a + 18'(j);
        n_cmp++;
        if (req_q[i].a !== ea || req_q[i].d !== sd[8 * (j % 4) +: 8]) begin
          n_mis++;
          $display("FAIL rdy_sw_byte%0d: got %h@%h expected %h@%h", j, req_q[i].d, req_q[i].a,
                   sd[8 * (j % 4) +: 8], ea);
        end
        j++;
      end
    end
    n_cmp++;
    if (j != 4) begin n_mis++; $display("FAIL rdy_sw_count: got %0d expected 4", j); end
    finish_op();
  endtask

  task automatic test_random();
    logic [5:0]  ids [9] = '{ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU, ID_SB, ID_SH, ID_SW, ID_ADD};
    logic [5:0]  id;
    logic [17:0] a, ea;
    logic [31:0] sd, exp_v;
    int gp, n, j;
    for (int it = 0; it < 40; it++) begin
      id = ids[$urandom_range(0, 8)];
      a  = ($urandom_range(0, 3) == 0) ? 18'h3FFFC + 18'($urandom_range(0, 3)) : 18'($urandom);
      sd = $urandom;
      rdE_in = 1'($urandom); rdIdx_in = 5'($urandom); rdData_in = $urandom;
      hold_in = 1'b0;
      if (id == ID_ADD) begin
        instIdx_in = id;
        #1;
        n_cmp++;
        if ({rdE_out, rdIdx_out, rdData_out, stallReq_out, memReq_out} !==
            {rdE_in, rdIdx_in, rdData_in, 2'b00}) begin
          n_mis++;
          $display("FAIL rnd_add%0d: got %b/%0d/%h stall=%b expected %b/%0d/%h stall=0",
                   it, rdE_out, rdIdx_out, rdData_out, stallReq_out, rdE_in, rdIdx_in, rdData_in);
        end
        @(posedge clk_in); #1;
      end else begin
        n = nbytes(id);
        exp_v = ref_load(id, a);
        gp = ($urandom_range(0, 1) == 0) ? 100 : int'($urandom_range(50, 99));
        drive_op(id, a, sd, gp, 32'h0, 32'h0);
        n_cmp++;
        if (done_cyc <= 0) begin n_mis++; $display("FAIL rnd_timeout%0d: got %0d expected >0", it, done_cyc); end
        if (gp == 100) begin
          n_cmp++;
          if (done_cyc != n + (is_load(id) ? 2 : 1)) begin
            n_mis++; $display("FAIL rnd_latency%0d: got %0d expected %0d", it, done_cyc, n + (is_load(id) ? 2 : 1));
          end
        end
        n_cmp++;
        if (is_load(id) ? ({done_rde, done_data} !== {rdE_in, exp_v}) : (done_rde !== 1'b0)) begin
          n_mis++;
          $display("FAIL rnd_result%0d: got rdE=%b data=%h expected rdE=%b data=%h", it, done_rde,
                   done_data, is_load(id) ? rdE_in : 1'b0, exp_v);
        end
        j = 0;
        for (int i = 0; i < req_q.size(); i++) begin
          if (req_q[i].g) begin
            ea = a + 18'(j);
            n_cmp++;
            if (req_q[i].a !== ea || req_q[i].wr !== !is_load(id) ||
                (!is_load(id) && req_q[i].d !== sd[8 * (j % 4) +: 8])) begin
              n_mis++;
              $display("FAIL rnd_req%0d_%0d: got %h@%h wr=%b expected %h@%h wr=%b", it, j, req_q[i].d,
                       req_q[i].a, req_q[i].wr, sd[8 * (j % 4) +: 8], ea, !is_load(id));
            end
            j++;
          end
        end
        n_cmp++;
        if (j != n) begin n_mis++; $display("FAIL rnd_count%0d: got %0d expected %0d", it, j, n); end
        finish_op();
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_word();
    test_load_edge();
    test_store_gap();
    test_hold_rdy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
